// File: rtl/mlp_seq_engine_pkg.sv
// Shared constants and types for the sequential 2-layer MLP engine.
// Register map, CTRL bit positions, FSM states and activation modes.
package mlp_pkg;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_INPUT  = 3'd1;
  localparam logic [2:0] A_WEIGHT = 3'd2;
  localparam logic [2:0] A_OUT    = 3'd3;
  localparam logic [2:0] A_PCLR   = 3'd4;

  localparam int B_RUN      = 0;
  localparam int B_DONE     = 1;
  localparam int B_IRQ_EN   = 2;
  localparam int B_LAYER    = 3;
  localparam int B_HID_LIN  = 4;
  localparam int B_OUT_RELU = 5;
  localparam int B_BUSY     = 6;
  localparam int B_ERR      = 7;
  localparam int B_SAT      = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_H_BIAS,
    S_H_MAC,
    S_H_ACT,
    S_O_BIAS,
    S_O_MAC,
    S_O_ACT,
    S_FIN
  } state_e;

  typedef enum logic {
    ACT_RELU,
    ACT_LINEAR
  } act_mode_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mlp_seq_engine_if.sv
// CPU register-bus interface of the MLP engine.
// The CPU side is the master; the engine is the slave.
interface mlp_seq_engine_if;
  logic        write_en;
  logic [2:0]  addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output write_en, addr, writedata,
    input  readdata, irq
  );

  modport slave (
    input  write_en, addr, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/mlp_mac_act.sv
// Shared accumulator: bias load, multiply-accumulate, shift and clamp.
// Build option MLP_SAT_STATUS_EN enables the saturation-hit output.
module mlp_mac_act
  import mlp_pkg::*;
#(
  parameter int DW        = 16,
  parameter int WGT_WIDTH = 16,
  parameter int MAC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        acc_en,
  input  logic                        act,
  input  act_mode_e                   act_mode,
  input  logic signed [WGT_WIDTH-1:0] bias,
  input  logic signed [DW-1:0]        opa,
  input  logic signed [WGT_WIDTH-1:0] opw,
  output logic signed [OUT_WIDTH-1:0] result,
  output logic                        sat_hit
);

  localparam logic signed [MAC_WIDTH-1:0] MAXV =
    MAC_WIDTH'({(OUT_WIDTH-1){1'b1}});
  localparam logic signed [MAC_WIDTH-1:0] MINV = ~MAXV;

  logic signed [MAC_WIDTH-1:0]    acc;
  logic signed [MAC_WIDTH-1:0]    r;
  logic signed [MAC_WIDTH-1:0]    bias_ext;
  logic signed [DW+WGT_WIDTH-1:0] prod;
  logic signed [OUT_WIDTH-1:0]    val;
  logic                           over;
  logic                           under;

  assign bias_ext = MAC_WIDTH'(bias) <<< FRAC_BITS;
  assign prod     = opa * opw;
  assign r        = acc >>> FRAC_BITS;
  assign over     = r > MAXV;
  assign under    = r < MINV;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= bias_ext;
    end else if (acc_en) begin
      acc <= acc + MAC_WIDTH'(prod);
    end
  end

  always_comb begin
    val = r[OUT_WIDTH-1:0];
    if (act_mode == ACT_RELU) begin
      if (r < 0)     val = '0;
      else if (over) val = MAXV[OUT_WIDTH-1:0];
    end else begin
      if (over)       val = MAXV[OUT_WIDTH-1:0];
      else if (under) val = MINV[OUT_WIDTH-1:0];
    end
    result = act ? val : '0;
  end

`ifdef MLP_SAT_STATUS_EN
  // ReLU zeroing a negative sum is normal behaviour, not saturation
  always_comb begin
    sat_hit = 1'b0;
    if (act) begin
      if (act_mode == ACT_RELU) sat_hit = over;
      else                      sat_hit = over | under;
    end
  end
`else
  assign sat_hit = 1'b0;
`endif

endmodule

// File: rtl/mlp_seq_engine.sv
// Register-bus MLP engine: hidden + output layer on one shared MAC.
// Build option MLP_SAT_STATUS_EN adds the sticky CTRL SAT flag.
module mlp_seq_engine
  import mlp_pkg::*;
#(
  parameter int N_INPUTS  = 2,
  parameter int N_HIDDEN  = 4,
  parameter int N_OUTPUT  = 2,
  parameter int IN_WIDTH  = 16,
  parameter int WGT_WIDTH = 16,
  parameter int MAC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_BITS = 8
) (
  input logic              clk,
  input logic              rst,
  mlp_seq_engine_if.slave  bus
);

  localparam int DW  = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
  localparam int NWH = N_HIDDEN * (N_INPUTS + 1);
  localparam int NWO = N_OUTPUT * (N_HIDDEN + 1);
  localparam int XI  = idx_w(N_INPUTS);
  localparam int HI  = idx_w(N_HIDDEN);
  localparam int YI  = idx_w(N_OUTPUT);
  localparam int WHI = idx_w(NWH);
  localparam int WOI = idx_w(NWO);
  localparam int CW  = 16;

  state_e state, state_n;
  logic [CW-1:0] nrn, k;

  logic signed [IN_WIDTH-1:0]  x  [N_INPUTS];
  logic signed [WGT_WIDTH-1:0] wh [NWH];
  logic signed [WGT_WIDTH-1:0] wo [NWO];
  logic signed [OUT_WIDTH-1:0] h  [N_HIDDEN];
  logic signed [OUT_WIDTH-1:0] yw [N_OUTPUT];
  logic signed [OUT_WIDTH-1:0] y  [N_OUTPUT];

  logic [XI-1:0]  in_ptr;
  logic [WHI-1:0] wh_ptr;
  logic [WOI-1:0] wo_ptr;
  logic in_ok, hid_ok, out_ok;

  logic irq_en, layer_sel, hid_lin, out_relu;
  logic done, err, sat;
  logic [31:0] out_idx;

  logic busy, wr_ctrl, run_req, run_go, push_en, all_ok;
  logic in_last, wh_last, wo_last;
  logic last_kh, last_ko, last_h, last_o;
  logic [WHI-1:0] hb_idx, hw_idx;
  logic [WOI-1:0] ob_idx, ow_idx;

  logic                        clr, mac, act;
  act_mode_e                   mode;
  logic signed [WGT_WIDTH-1:0] bias, opw;
  logic signed [DW-1:0]        opa;
  logic signed [OUT_WIDTH-1:0] result;
  logic                        sat_hit;

  assign busy    = state != S_IDLE;
  assign all_ok  = in_ok & hid_ok & out_ok;
  assign wr_ctrl = bus.write_en && bus.addr == A_CTRL;
  assign run_req = wr_ctrl && bus.writedata[B_RUN];
  assign run_go  = run_req && !busy && all_ok;
  assign push_en = bus.write_en && !busy;

  assign in_last = in_ptr == XI'(N_INPUTS - 1);
  assign wh_last = wh_ptr == WHI'(NWH - 1);
  assign wo_last = wo_ptr == WOI'(NWO - 1);
  assign last_kh = k == CW'(N_INPUTS - 1);
  assign last_ko = k == CW'(N_HIDDEN - 1);
  assign last_h  = nrn == CW'(N_HIDDEN - 1);
  assign last_o  = nrn == CW'(N_OUTPUT - 1);

  assign hb_idx = WHI'(int'(nrn) * (N_INPUTS + 1));
  assign hw_idx = WHI'(int'(nrn) * (N_INPUTS + 1) + int'(k) + 1);
  assign ob_idx = WOI'(int'(nrn) * (N_HIDDEN + 1));
  assign ow_idx = WOI'(int'(nrn) * (N_HIDDEN + 1) + int'(k) + 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    clr     = 1'b0;
    mac     = 1'b0;
    act     = 1'b0;
    mode    = ACT_RELU;
    bias    = '0;
    opa     = '0;
    opw     = '0;
    unique case (state)
      S_IDLE: if (run_go) state_n = S_H_BIAS;
      S_H_BIAS: begin
        clr     = 1'b1;
        bias    = wh[hb_idx];
        state_n = S_H_MAC;
      end
      S_H_MAC: begin
        mac = 1'b1;
        opa = DW'(x[XI'(k)]);
        opw = wh[hw_idx];
        if (last_kh) state_n = S_H_ACT;
      end
      S_H_ACT: begin
        act     = 1'b1;
        mode    = hid_lin ? ACT_LINEAR : ACT_RELU;
        state_n = last_h ? S_O_BIAS : S_H_BIAS;
      end
      S_O_BIAS: begin
        clr     = 1'b1;
        bias    = wo[ob_idx];
        state_n = S_O_MAC;
      end
      S_O_MAC: begin
        mac = 1'b1;
        opa = DW'(h[HI'(k)]);
        opw = wo[ow_idx];
        if (last_ko) state_n = S_O_ACT;
      end
      S_O_ACT: begin
        act     = 1'b1;
        mode    = out_relu ? ACT_RELU : ACT_LINEAR;
        state_n = last_o ? S_FIN : S_O_BIAS;
      end
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nrn <= '0;
      k   <= '0;
    end else begin
      unique case (state)
        S_H_BIAS, S_O_BIAS: k <= '0;
        S_H_MAC, S_O_MAC:   k <= k + 1'b1;
        S_H_ACT:            nrn <= last_h ? '0 : nrn + 1'b1;
        S_O_ACT:            nrn <= nrn + 1'b1;
        default: begin
          nrn <= '0;
          k   <= '0;
        end
      endcase
    end
  end

  mlp_mac_act #(
    .DW        (DW),
    .WGT_WIDTH (WGT_WIDTH),
    .MAC_WIDTH (MAC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clear    (clr),
    .acc_en   (mac),
    .act      (act),
    .act_mode (mode),
    .bias     (bias),
    .opa      (opa),
    .opw      (opw),
    .result   (result),
    .sat_hit  (sat_hit)
  );

  // storage arrays carry no reset; the ok flags gate their use
  always_ff @(posedge clk) begin
    if (push_en && bus.addr == A_INPUT)
      x[in_ptr] <= bus.writedata[IN_WIDTH-1:0];
    if (push_en && bus.addr == A_WEIGHT) begin
      if (layer_sel) wo[wo_ptr] <= bus.writedata[WGT_WIDTH-1:0];
      else           wh[wh_ptr] <= bus.writedata[WGT_WIDTH-1:0];
    end
    if (state == S_H_ACT) h[HI'(nrn)]  <= result;
    if (state == S_O_ACT) yw[YI'(nrn)] <= result;
  end

  // published results only change at FIN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_OUTPUT; i++) y[i] <= '0;
    end else if (state == S_FIN) begin
      y <= yw;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_en    <= 1'b0;
      layer_sel <= 1'b0;
      hid_lin   <= 1'b0;
      out_relu  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      out_idx   <= '0;
      in_ptr    <= '0;
      wh_ptr    <= '0;
      wo_ptr    <= '0;
      in_ok     <= 1'b0;
      hid_ok    <= 1'b0;
      out_ok    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        irq_en    <= bus.writedata[B_IRQ_EN];
        layer_sel <= bus.writedata[B_LAYER];
        hid_lin   <= bus.writedata[B_HID_LIN];
        out_relu  <= bus.writedata[B_OUT_RELU];
      end
      if (run_req && !busy) err <= !all_ok;
      if (run_go)
        done <= 1'b0;
      else if (state == S_FIN)
        done <= 1'b1;
      else if (wr_ctrl && bus.writedata[B_DONE])
        done <= 1'b0;
      if (bus.write_en && bus.addr == A_OUT)
        out_idx <= bus.writedata;
      if (push_en) begin
        unique case (1'b1)
          bus.addr == A_INPUT: begin
            in_ptr <= in_last ? '0 : in_ptr + 1'b1;
            if (in_last) in_ok <= 1'b1;
          end
          bus.addr == A_WEIGHT && layer_sel: begin
            wo_ptr <= wo_last ? '0 : wo_ptr + 1'b1;
            if (wo_last) out_ok <= 1'b1;
          end
          bus.addr == A_WEIGHT && !layer_sel: begin
            wh_ptr <= wh_last ? '0 : wh_ptr + 1'b1;
            if (wh_last) hid_ok <= 1'b1;
          end
          bus.addr == A_PCLR: begin
            in_ptr <= '0;
            wh_ptr <= '0;
            wo_ptr <= '0;
            in_ok  <= 1'b0;
            hid_ok <= 1'b0;
            out_ok <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MLP_SAT_STATUS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         sat <= 1'b0;
    else if (run_go)  sat <= 1'b0;
    else if (sat_hit) sat <= 1'b1;
  end
`else
  logic unused_sat;
  assign unused_sat = sat_hit;
  assign sat        = 1'b0;
`endif

  always_comb begin
    bus.readdata = '0;
    unique case (bus.addr)
      A_CTRL: bus.readdata = 32'({sat, err, busy, out_relu,
                                  hid_lin, layer_sel, irq_en,
                                  done, 1'b0});
      A_OUT:
        if (out_idx < 32'(N_OUTPUT))
          bus.readdata = 32'(y[YI'(out_idx)]);
      default: bus.readdata = '0;
    endcase
  end

  assign bus.irq = done & irq_en;

endmodule
